axi_stream_slave: RTL and testbench
===================================

AXI_STREAM_SLAVE -- requirements
Module: axi_stream_slave

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, width of the stream data.
- DEPTH, 4, receive FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the pixel and line counters.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all flops on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- s_axis_tdata, in, DATA_WIDTH, upstream data.
- s_axis_tvalid, in, 1, upstream valid.
- s_axis_tready, out, 1, ready to upstream.
- s_axis_tlast, in, 1, end of line.
- s_axis_tuser, in, 1, start of frame.
- data_out, out, DATA_WIDTH, FIFO head data.
- valid_out, out, 1, FIFO head is valid.
- last_out, out, 1, FIFO head tlast.
- user_out, out, 1, FIFO head tuser.
- ready_in, in, 1, downstream consumer accepts the head.
- pixel_cnt, out, CNT_WIDTH, accepted beats in the current line.
- line_cnt, out, CNT_WIDTH, completed lines in the current frame.
- sof_err, out, 1, sticky error: frame start arrived mid-line.

Function
REQ-003 Accept: a beat is accepted on a clk edge where s_axis_tvalid=1 and s_axis_tready=1; no other condition accepts a beat.

REQ-004 FIFO storage: the FIFO stores {user, last, data} per entry and preserves arrival order.

REQ-005 s_axis_tready: equals ready_en AND (count < DEPTH), purely combinational from registers.
- ready_en is a flop, cleared by reset and set on the first clk edge after rst_n deasserts.

REQ-006 Show-ahead output: valid_out = (count != 0); data_out, last_out and user_out always present the head entry.

REQ-007 Empty outputs: when count = 0, data_out, last_out and user_out are driven to 0.

REQ-008 Pop: the head is popped on an edge where valid_out=1 and ready_in=1.

REQ-009 Latency: a beat accepted into an empty FIFO appears on valid_out exactly 1 cycle after acceptance; there is no combinational bypass.

REQ-010 Simultaneous push and pop: count is unchanged and both operations take effect.
- When full, tready=0, so a pop frees the slot; a new beat can be accepted only from the following cycle.

REQ-011 Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits and ranges 0..DEPTH.

REQ-012 Counters, updated on each accepted beat (tuser = s_axis_tuser, tlast = s_axis_tlast):
- tlast=1: pixel_cnt becomes 0; line_cnt becomes (tuser ? 0 : line_cnt) + 1.
- tlast=0: pixel_cnt becomes (tuser ? 0 : pixel_cnt) + 1; line_cnt becomes (tuser ? 0 : line_cnt).

REQ-013 Counter width: both counters wrap modulo 2^CNT_WIDTH with no saturation.

REQ-014 Counter hold: the counters hold when no beat is accepted, independent of the downstream side.

REQ-015 sof_err: set on an accepted beat with tuser=1 while pixel_cnt != 0; once set it stays 1 until reset.
- The offending beat is still stored in the FIFO and counted per REQ-012.

REQ-016 Unaccepted inputs: changes on s_axis_* while tready=0 have no effect.

REQ-017 Downstream stall: ready_in=0 with valid_out=1 holds the head stable until it is popped.

Reset
REQ-018 Async reset: rst_n low immediately clears the following, regardless of clk:
- count, pointers, ready_en, pixel_cnt, line_cnt and sof_err.

REQ-019 Outputs during reset: while rst_n is low, s_axis_tready=0, valid_out=0, data_out=0, last_out=0, user_out=0, pixel_cnt=0, line_cnt=0 and sof_err=0.

REQ-020 Reset mid-operation: FIFO contents are discarded; after release the block behaves as freshly reset.
- The first accepted beat is treated as mid-frame unless it has tuser=1.

REQ-021 FIFO data storage: the data storage array needs no reset; only the control state defined above is reset.

Verification
REQ-022 The bench shall cover at least these directed scenarios:
- Reset release: tready=0 in the first cycle after rst_n rises, 1 from the next cycle; valid_out=0; counters at 0.
- Single beat: data 0xA5A5A5A5 with tuser=1 and ready_in=1.
  - valid_out=1 one cycle after accept with data_out=0xA5A5A5A5 and user_out=1.
  - pixel_cnt=1 after accept.
- Fill and stall: ready_in=0 with 5 beats 0x1..0x5 offered.
  - Beats 0x1..0x4 are accepted; tready=0 after the 4th; 0x5 is held.
  - Raising ready_in pops the beats in order 0x1,0x2,0x3,0x4,0x5.
- Line and frame: frame of 3 lines x 4 beats, tuser on the first beat, tlast on every 4th.
  - line_cnt ends at 3 and pixel_cnt at 0; sof_err=0.
  - A new tuser beat then gives line_cnt=0 and pixel_cnt=1.
- Mid-line frame start: 2 beats without tlast, then a tuser beat.
  - sof_err=1 and stays 1; pixel_cnt=1 after the tuser beat.
- Async reset mid-operation: FIFO holding 3 entries, rst_n pulsed low between clock edges.
  - valid_out, tready and the counters drop to 0 immediately; no old data is seen after release.

Source files
------------

// File: rtl/axi_stream_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_slave
// Description : AXI4-Stream video slave. Buffers {tuser, tlast, tdata} beats
//               in a small show-ahead FIFO and tracks the pixel position in
//               the current line, the number of completed lines in the
//               current frame, and a sticky "frame start mid-line" error.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous active-low reset
//   s_axis_tdata   in   DATA_WIDTH  upstream data
//   s_axis_tvalid  in   1           upstream valid
//   s_axis_tready  out  1           ready to upstream
//   s_axis_tlast   in   1           end of line
//   s_axis_tuser   in   1           start of frame
//   data_out       out  DATA_WIDTH  FIFO head data (0 when empty)
//   valid_out      out  1           FIFO head valid
//   last_out       out  1           FIFO head tlast (0 when empty)
//   user_out       out  1           FIFO head tuser (0 when empty)
//   ready_in       in   1           downstream accepts the head
//   pixel_cnt      out  CNT_WIDTH   accepted beats in the current line
//   line_cnt       out  CNT_WIDTH   completed lines in the current frame
//   sof_err        out  1           sticky: frame start arrived mid-line
// ============================================================================
module axi_stream_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic                  user_out,
  input  logic                  ready_in,
  output logic [CNT_WIDTH-1:0]  pixel_cnt,
  output logic [CNT_WIDTH-1:0]  line_cnt,
  output logic                  sof_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;   // {user, last, data}

  localparam logic [AW:0]          c_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]          c_ONE_CNT = (AW+1)'(1);
  localparam logic [AW-1:0]        c_ONE_PTR = AW'(1);
  localparam logic [CNT_WIDTH-1:0] c_ONE_PIX = CNT_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [EW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_ready_en;
  logic [CNT_WIDTH-1:0] r_pixel_cnt;
  logic [CNT_WIDTH-1:0] r_line_cnt;
  logic                 r_sof_err;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic          w_full;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == c_DEPTH);
  assign w_valid = (r_count != '0);

  // Ready depends only on registers, so a pop on a full FIFO cannot admit
  // a new beat in the same cycle; the slot becomes usable one cycle later.
  assign s_axis_tready = r_ready_en & ~w_full;

  assign w_push = s_axis_tvalid & s_axis_tready;
  assign w_pop  = w_valid & ready_in;

  // --------------------------------------------------------------------------
  // Storage: data array carries no reset, only control state is reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  // Ready enable comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE_CNT;
        2'b01:   r_count <= r_count - c_ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead head; outputs are forced to zero while empty so stale
  // storage contents never leak downstream.
  // --------------------------------------------------------------------------
  assign w_head    = r_mem[r_rd_ptr];
  assign valid_out = w_valid;
  assign data_out  = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign last_out  = w_valid ? w_head[DATA_WIDTH]     : 1'b0;
  assign user_out  = w_valid ? w_head[DATA_WIDTH+1]   : 1'b0;

  // --------------------------------------------------------------------------
  // Line / frame position tracking, driven only by accepted beats.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_cnt <= '0;
      r_line_cnt  <= '0;
      r_sof_err   <= 1'b0;
    end else if (w_push) begin
      // A frame start while part-way through a line means the previous
      // line was truncated; the beat is still stored and counted.
      if (s_axis_tuser && (r_pixel_cnt != '0)) begin
        r_sof_err <= 1'b1;
      end
      if (s_axis_tlast) begin
        r_pixel_cnt <= '0;
        r_line_cnt  <= (s_axis_tuser ? '0 : r_line_cnt) + c_ONE_PIX;
      end else begin
        r_pixel_cnt <= (s_axis_tuser ? '0 : r_pixel_cnt) + c_ONE_PIX;
        r_line_cnt  <= s_axis_tuser ? '0 : r_line_cnt;
      end
    end
  end

  assign pixel_cnt = r_pixel_cnt;
  assign line_cnt  = r_line_cnt;
  assign sof_err   = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_slave
// Description : Self-checking bench for axi_stream_slave. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios add literal expectations, followed by random
//               traffic with a mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_slave;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;   // narrow counters so random traffic wraps them

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          last_out;
  logic          user_out;
  logic          ready_in = 1'b0;
  logic [CW-1:0] pixel_cnt;
  logic [CW-1:0] line_cnt;
  logic          sof_err;

  axi_stream_slave #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .last_out      (last_out),
    .user_out      (user_out),
    .ready_in      (ready_in),
    .pixel_cnt     (pixel_cnt),
    .line_cnt      (line_cnt),
    .sof_err       (sof_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of {user,last,data}, plus line/frame position.
  // Inputs are stable across each negedge, so the model checks outputs there
  // and then advances to the state after the following rising edge.
  // --------------------------------------------------------------------------
  logic [DW+1:0] m_q[$];
  bit            m_ready_en = 0;
  logic [CW-1:0] m_pix = '0;
  logic [CW-1:0] m_line = '0;
  logic          m_sof = 1'b0;

  always @(negedge clk) begin
    logic          exp_tready, exp_valid, push, pop;
    logic [DW+1:0] head;
    if (!rst_n) begin
      m_q.delete();
      m_ready_en = 0;
      m_pix      = '0;
      m_line     = '0;
      m_sof      = 1'b0;
      check("rst_tready", s_axis_tready, 0);
      check("rst_valid",  valid_out, 0);
      check("rst_data",   {user_out, last_out, data_out}, 0);
      check("rst_cnt",    {pixel_cnt, line_cnt, sof_err}, 0);
    end else begin
      exp_tready = m_ready_en && (m_q.size() < DEPTH);
      exp_valid  = (m_q.size() != 0);
      head       = exp_valid ? m_q[0] : '0;
      check("m_tready", s_axis_tready, exp_tready);
      check("m_valid",  valid_out, exp_valid);
      check("m_data",   data_out, head[DW-1:0]);
      check("m_last",   last_out, head[DW]);
      check("m_user",   user_out, head[DW+1]);
      check("m_pixel",  pixel_cnt, m_pix);
      check("m_line",   line_cnt, m_line);
      check("m_sof",    sof_err, m_sof);
      push = s_axis_tvalid && exp_tready;
      pop  = exp_valid && ready_in;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({s_axis_tuser, s_axis_tlast, s_axis_tdata});
        if (s_axis_tuser && m_pix != 0) m_sof = 1'b1;
        if (s_axis_tlast) begin
          m_line = (s_axis_tuser ? CW'(0) : m_line) + CW'(1);
          m_pix  = '0;
        end else begin
          m_pix  = (s_axis_tuser ? CW'(0) : m_pix) + CW'(1);
          if (s_axis_tuser) m_line = '0;
        end
      end
      m_ready_en = 1;
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    bit done;
    done          = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (s_axis_tready) done = 1;
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  initial begin
    logic [DW-1:0] got[$];
    bit            acc;

    // ---------------- Reset release ----------------
    repeat (3) step();
    check("inrst_tready", s_axis_tready, 0);
    rst_n = 1'b1;
    check("rel_tready_first", s_axis_tready, 0);
    step();
    check("rel_tready_next", s_axis_tready, 1);
    check("rel_valid", valid_out, 0);
    check("rel_pixel", pixel_cnt, 0);
    check("rel_line",  line_cnt, 0);

    // ---------------- Single beat ----------------
    ready_in = 1'b1;
    send_beat(32'hA5A5A5A5, 1'b1, 1'b0);
    check("single_valid", valid_out, 1);
    check("single_data",  data_out, 32'hA5A5A5A5);
    check("single_user",  user_out, 1);
    check("single_pixel", pixel_cnt, 1);
    step();
    check("single_popped", valid_out, 0);

    // ---------------- Fill and stall ----------------
    ready_in = 1'b0;
    for (int k = 1; k <= 4; k++) send_beat(DW'(k), 1'b0, 1'b0);
    check("fill_tready_full", s_axis_tready, 0);
    s_axis_tdata  = 32'h5;
    s_axis_tvalid = 1'b1;
    step();
    step();
    check("stall_tready", s_axis_tready, 0);
    check("stall_head",   data_out, 32'h1);
    ready_in = 1'b1;
    for (int i = 0; i < 30 && got.size() < 5; i++) begin
      if (valid_out && ready_in) got.push_back(data_out);
      acc = s_axis_tvalid && s_axis_tready;
      step();
      if (acc) s_axis_tvalid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    check("drain_count", got.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) check("drain_order", got[k], k + 1);
    end

    // ---------------- Line and frame ----------------
    send_beat(32'h77, 1'b0, 1'b1);   // close the open line
    check("close_pixel", pixel_cnt, 0);
    for (int b = 0; b < 12; b++) begin
      send_beat(32'h100 + DW'(b), (b == 0), ((b % 4) == 3));
    end
    check("frame_line",  line_cnt, 3);
    check("frame_pixel", pixel_cnt, 0);
    check("frame_sof",   sof_err, 0);
    send_beat(32'h200, 1'b1, 1'b0);
    check("newframe_line",  line_cnt, 0);
    check("newframe_pixel", pixel_cnt, 1);

    // ---------------- Mid-line frame start ----------------
    send_beat(32'h301, 1'b0, 1'b0);
    send_beat(32'h302, 1'b0, 1'b0);
    check("midline_pre_sof", sof_err, 0);
    send_beat(32'h303, 1'b1, 1'b0);
    check("midline_sof",   sof_err, 1);
    check("midline_pixel", pixel_cnt, 1);
    repeat (4) step();
    check("midline_sticky", sof_err, 1);

    // ---------------- Async reset mid-operation ----------------
    repeat (4) step();               // drain whatever is left
    ready_in = 1'b0;
    send_beat(32'hDEAD0001, 1'b0, 1'b0);
    send_beat(32'hDEAD0002, 1'b0, 1'b0);
    send_beat(32'hDEAD0003, 1'b0, 1'b0);
    check("arst_pre_valid", valid_out, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid",  valid_out, 0);
    check("arst_tready", s_axis_tready, 0);
    check("arst_data",   data_out, 0);
    check("arst_cnts",   {pixel_cnt, line_cnt, sof_err}, 0);
    @(posedge clk);
    #3;
    rst_n    = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("arst_no_old_data", valid_out, 0);
    end

    // ---------------- Random traffic ----------------
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      s_axis_tlast  = ($urandom_range(0, 23) == 0);
      s_axis_tuser  = ($urandom_range(0, 39) == 0);
      ready_in      = ($urandom_range(0, 2) != 0);
      if (c == 1500) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
      step();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
